// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier back-end: default widths and FSM state
// encoding used by the product accumulator.
package mult_pkg;

  localparam int unsigned PROD_W = 64;  // product width from the multiplier tree
  localparam int unsigned ACC_W  = 72;  // accumulator width, >= PROD_W
  localparam int unsigned CNT_W  = 8;   // beat-count field width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : mult_pkg

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle for product_accumulator.
//   in_valid/in_ready/prod            : product stream from the multiplier
//   out_valid/out_ready/acc_out/ovf   : job result towards the consumer
// slave = accumulator side, master = producer/consumer side.
interface product_accumulator_if #(
  parameter int unsigned PROD_W = mult_pkg::PROD_W,
  parameter int unsigned ACC_W  = mult_pkg::ACC_W
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  modport slave (
    input  in_valid, prod, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );

  modport master (
    output in_valid, prod, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

endinterface : product_accumulator_if

// File: rtl/product_accumulator_sat_add.sv
// sat_add: combinational ACC_W-bit signed adder with overflow flag.
//   a, b : signed operands
//   sum  : a + b (wrapped, or clamped when SATURATE_EN is defined)
//   ovf  : signed overflow of a + b
// Build option: SATURATE_EN clamps overflowing results to the signed limits.
module sat_add #(
  parameter int unsigned ACC_W = mult_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic signed [ACC_W-1:0] raw;

  // Overflow: operands share a sign that the wrapped result does not.
  always_comb begin
    raw = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef SATURATE_EN
    sum = raw;
    if (ovf) begin
      sum = a[ACC_W-1] ? MIN_V : MAX_V;
    end
`else
    sum = raw;
`endif
  end

endmodule : sat_add

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of signed products into a wide
// accumulator and presents the job result over a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, len  : job start pulse and product count (sampled in IDLE only)
//   clr         : synchronous abort back to IDLE, highest priority
//   busy        : FSM not in IDLE
//   bus         : product_accumulator_if.slave (product in, result out)
// Build option: SATURATE_EN (in sat_add) clamps the accumulator on overflow.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned PROD_W = mult_pkg::PROD_W,
  parameter int unsigned ACC_W  = mult_pkg::ACC_W,
  parameter int unsigned CNT_W  = mult_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             clr,
  output logic             busy,
  product_accumulator_if.slave bus
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic                    in_ready_q, out_valid_q, busy_q;
  logic [ACC_W-1:0]        acc_out_q;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    beat;

  // Sign-extend the product to accumulator width.
  assign prod_ext = ACC_W'(signed'(bus.prod));

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Next-state, accumulator and counter update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    beat    = bus.in_valid && in_ready_q;

    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_d = '0;
            ovf_d = 1'b0;
            if (len != '0) begin
              state_d = ST_ACCUM;
              rem_d   = len;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_ovf;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_valid_q && bus.out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      rem_q       <= rem_d;
      in_ready_q  <= (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
      acc_out_q   <= (state_d == ST_DONE) ? acc_d : '0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;
  assign busy          = busy_q;

endmodule : product_accumulator
